// File: rtl/fu_issue_queue_if.sv
// Issue-queue bus: router-side allocate, wakeup broadcast, PRF read port and
// FU issue handshake. The router/FU/PRF side is master, the queue is slave.
interface fu_issue_queue_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int DEPTH        = 8
);
  localparam int OCC_BITS = $clog2(DEPTH + 1);

  logic                                              flush;
  logic                                              inst_valid;
  logic                                              queue_ready;
  logic [INST_ID_BITS-1:0]                           inst_id;
  logic [31:0]                                       raw_instr;
  logic [63:0]                                       instr_pc;
  logic [MAX_OPERANDS-1:0]                           prn_input_valid;
  logic [MAX_OPERANDS-1:0]                           prn_input_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_input;
  logic [MAX_OPERANDS-1:0]                           prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_output;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]             set_prn_ready;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn;
  logic [MAX_OPERANDS-1:0]                           prf_read_enable;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prf_read_prn;
  logic [MAX_OPERANDS-1:0][63:0]                     prf_op;
  logic                                              fu_issue_valid;
  logic                                              fu_issue_ready;
  logic [INST_ID_BITS-1:0]                           fu_inst_id;
  logic [31:0]                                       fu_raw_instr;
  logic [63:0]                                       fu_instr_pc;
  logic [MAX_OPERANDS-1:0][63:0]                     fu_operands;
  logic [MAX_OPERANDS-1:0]                           fu_prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             fu_prn_output;
  logic [OCC_BITS-1:0]                               occupancy;

  modport master (
    output flush, inst_valid, inst_id, raw_instr, instr_pc,
           prn_input_valid, prn_input_ready, prn_input,
           prn_output_valid, prn_output, set_prn_ready, set_prn,
           prf_op, fu_issue_ready,
    input  queue_ready, prf_read_enable, prf_read_prn, fu_issue_valid,
           fu_inst_id, fu_raw_instr, fu_instr_pc, fu_operands,
           fu_prn_output_valid, fu_prn_output, occupancy
  );

  modport slave (
    input  flush, inst_valid, inst_id, raw_instr, instr_pc,
           prn_input_valid, prn_input_ready, prn_input,
           prn_output_valid, prn_output, set_prn_ready, set_prn,
           prf_op, fu_issue_ready,
    output queue_ready, prf_read_enable, prf_read_prn, fu_issue_valid,
           fu_inst_id, fu_raw_instr, fu_instr_pc, fu_operands,
           fu_prn_output_valid, fu_prn_output, occupancy
  );
endinterface

// File: rtl/fu_issue_queue.sv
// Per-FU issue queue: compacting age-ordered entry array (index 0 oldest),
// broadcast wakeup, oldest-ready select with PRF read, and a one-deep read
// stage that captures PRF data so operands survive FU back-pressure.
module fu_issue_queue #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int DEPTH        = 8
) (
  input  logic            clk,
  input  logic            rst,
  fu_issue_queue_if.slave bus
);
  localparam int OCC_BITS = $clog2(DEPTH + 1);
  localparam int IDX_BITS = $clog2(DEPTH);

  typedef logic [MAX_OPERANDS-1:0]                             slot_t;
  typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prn_vec_t;
  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               bc_vld_t;
  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] bc_prn_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] id;
    logic [31:0]             instr;
    logic [63:0]             pc;
    slot_t                   src_v;
    slot_t                   src_r;
    prn_vec_t                src_p;
    slot_t                   dst_v;
    prn_vec_t                dst_p;
  } entry_t;

  // Read-stage payload; ready bits and source PRNs are no longer needed here
  typedef struct packed {
    logic [INST_ID_BITS-1:0] id;
    logic [31:0]             instr;
    logic [63:0]             pc;
    slot_t                   src_v;
    slot_t                   dst_v;
    prn_vec_t                dst_p;
  } issue_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_FRESH, ST_HELD} stage_e;

  function automatic logic bcast_hit(input logic [PRN_BITS-1:0] prn,
                                     input bc_vld_t vld, input bc_prn_t p);
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < FU_COUNT; f++)
      for (int k = 0; k < MAX_OPERANDS; k++)
        if (vld[f][k] && (p[f][k] == prn)) hit = 1'b1;
    return hit;
  endfunction

  entry_t                        ent_q [DEPTH];
  entry_t                        ent_d [DEPTH];
  entry_t                        woke  [DEPTH];
  entry_t                        new_ent;
  entry_t                        sel_ent;
  logic [OCC_BITS-1:0]           count_q, count_d, wr_idx;
  logic [IDX_BITS-1:0]           sel_idx;
  logic                          sel_found, can_sel, sel_fire, alloc, q_ready;
  logic                          hs, issue_vld, use_fresh;
  stage_e                        state_q, state_d;
  issue_t                        stg_q;
  logic [MAX_OPERANDS-1:0][63:0] ops_q;

  // Full is judged on the registered count, so a same-cycle select never frees a slot early
  assign q_ready  = !rst && (count_q != OCC_BITS'(DEPTH));
  assign alloc    = bus.inst_valid && q_ready && !bus.flush;
  assign can_sel  = (state_q == ST_EMPTY) || bus.fu_issue_ready;
  assign sel_fire = sel_found && can_sel && !bus.flush;
  assign sel_ent  = ent_q[sel_idx];
  assign hs       = issue_vld && bus.fu_issue_ready;
  assign wr_idx   = count_q - OCC_BITS'(sel_fire);

  assign bus.queue_ready = q_ready;
  assign bus.occupancy   = count_q;

  // Incoming entry: a source is ready if unused, already written, or broadcast this cycle
  always_comb begin
    new_ent       = '0;
    new_ent.id    = bus.inst_id;
    new_ent.instr = bus.raw_instr;
    new_ent.pc    = bus.instr_pc;
    new_ent.src_v = bus.prn_input_valid;
    new_ent.src_p = bus.prn_input;
    new_ent.dst_v = bus.prn_output_valid;
    new_ent.dst_p = bus.prn_output;
    for (int k = 0; k < MAX_OPERANDS; k++)
      new_ent.src_r[k] = !bus.prn_input_valid[k] || bus.prn_input_ready[k] ||
                         bcast_hit(bus.prn_input[k], bus.set_prn_ready, bus.set_prn);
  end

  // Oldest ready entry, judged on registered ready bits only
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if ((OCC_BITS'(i) < count_q) && ((ent_q[i].src_v & ~ent_q[i].src_r) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_BITS'(i);
      end
  end

  // Wakeup of waiting sources from this cycle's broadcasts
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      for (int k = 0; k < MAX_OPERANDS; k++)
        if (ent_q[i].src_v[k] && bcast_hit(ent_q[i].src_p[k], bus.set_prn_ready, bus.set_prn))
          woke[i].src_r[k] = 1'b1;
    end
  end

  // Compaction: entries above the selected one shift down, new entry lands at the top
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = woke[i];
    for (int i = 0; i < DEPTH - 1; i++)
      if (sel_fire && (IDX_BITS'(i) >= sel_idx)) ent_d[i] = woke[i + 1];
    for (int i = 0; i < DEPTH; i++)
      if (alloc && (OCC_BITS'(i) == wr_idx)) ent_d[i] = new_ent;
  end

  // Occupancy bookkeeping; flush wins over allocate and select
  always_comb begin
    count_d = count_q + OCC_BITS'(alloc) - OCC_BITS'(sel_fire);
    if (bus.flush) count_d = '0;
  end

  // Entry count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Entry payload storage; validity is carried by count_q alone
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // PRF read strobes for the selected entry
  always_comb begin
    bus.prf_read_enable = '0;
    bus.prf_read_prn    = '0;
    if (sel_fire) begin
      bus.prf_read_enable = sel_ent.src_v;
      bus.prf_read_prn    = sel_ent.src_p;
    end
  end

  // ---- read stage ----

  // Read-stage state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Read-stage next state; selection while occupied implies a handshake
  always_comb begin
    state_d = state_q;
    if (bus.flush)              state_d = ST_EMPTY;
    else if (sel_fire)          state_d = ST_FRESH;
    else if (state_q == ST_EMPTY) state_d = ST_EMPTY;
    else if (hs)                state_d = ST_EMPTY;
    else                        state_d = ST_HELD;
  end

  // Read-stage control outputs
  always_comb begin
    issue_vld = (state_q != ST_EMPTY);
    use_fresh = (state_q == ST_FRESH);
  end

  // Read-stage payload and operand capture (PRF data is live only in FRESH)
  always_ff @(posedge clk) begin
    if (sel_fire) begin
      stg_q.id    <= sel_ent.id;
      stg_q.instr <= sel_ent.instr;
      stg_q.pc    <= sel_ent.pc;
      stg_q.src_v <= sel_ent.src_v;
      stg_q.dst_v <= sel_ent.dst_v;
      stg_q.dst_p <= sel_ent.dst_p;
    end
    if (state_q == ST_FRESH) ops_q <= bus.prf_op;
  end

  // Issue bundle, zeroed while the stage is empty and for unused source slots
  always_comb begin
    bus.fu_issue_valid      = issue_vld;
    bus.fu_inst_id          = issue_vld ? stg_q.id    : '0;
    bus.fu_raw_instr        = issue_vld ? stg_q.instr : '0;
    bus.fu_instr_pc         = issue_vld ? stg_q.pc    : '0;
    bus.fu_prn_output_valid = issue_vld ? stg_q.dst_v : '0;
    bus.fu_prn_output       = issue_vld ? stg_q.dst_p : '0;
    bus.fu_operands         = '0;
    for (int k = 0; k < MAX_OPERANDS; k++)
      if (issue_vld && stg_q.src_v[k])
        bus.fu_operands[k] = use_fresh ? bus.prf_op[k] : ops_q[k];
  end
endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model.
module tb_fu_issue_queue;
  localparam int IB = 6, PB = 6, MO = 3, FC = 4, D = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fu_issue_queue_if #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
                      .FU_COUNT(FC), .DEPTH(D)) bus ();

  fu_issue_queue #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
                   .FU_COUNT(FC), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [IB-1:0]         id;
    logic [31:0]           instr;
    logic [63:0]           pc;
    logic [MO-1:0]         sv;
    logic [MO-1:0]         sr;
    logic [MO-1:0][PB-1:0] sp;
    logic [MO-1:0]         dv;
    logic [MO-1:0][PB-1:0] dp;
  } m_ent_t;

  // Reference model: waiting instructions in age order plus the issue slot
  m_ent_t                mq [$];
  logic                  st_v = 1'b0;
  logic                  st_fresh = 1'b0;
  m_ent_t                st_e;
  logic [MO-1:0][63:0]   st_ops;

  int n_cmp = 0, n_bad = 0;
  int strobe_cnt = 0;
  logic [IB-1:0] issued [$];
  logic [MO-1:0] obs_en;
  logic obs_vld, obs_qr;
  logic [IB-1:0] obs_id;
  logic [$clog2(D+1)-1:0] obs_occ;
  logic [MO-1:0][63:0] obs_ops;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tb_hit(input logic [PB-1:0] p);
    for (int f = 0; f < FC; f++)
      for (int k = 0; k < MO; k++)
        if (bus.set_prn_ready[f][k] && bus.set_prn[f][k] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.flush = 0; bus.inst_valid = 0; bus.inst_id = '0; bus.raw_instr = '0;
    bus.instr_pc = '0; bus.prn_input_valid = '0; bus.prn_input_ready = '0;
    bus.prn_input = '0; bus.prn_output_valid = '0; bus.prn_output = '0;
    bus.set_prn_ready = '0; bus.set_prn = '0; bus.fu_issue_ready = 0;
  endtask

  task automatic set_alloc(input int id, input logic [MO-1:0] v, input logic [MO-1:0] r,
                           input logic [MO-1:0][PB-1:0] p);
    bus.inst_valid = 1; bus.inst_id = id[IB-1:0];
    bus.raw_instr = $urandom; bus.instr_pc = {$urandom, $urandom};
    bus.prn_input_valid = v; bus.prn_input_ready = r; bus.prn_input = p;
    bus.prn_output_valid = MO'($urandom);
    for (int k = 0; k < MO; k++) bus.prn_output[k] = PB'($urandom);
  endtask

  task automatic bcast(input int f, input int k, input logic [PB-1:0] p);
    bus.set_prn_ready[f][k] = 1'b1;
    bus.set_prn[f][k] = p;
  endtask

  // One clock: compare DUT against model at the falling edge, then advance the model
  task automatic step();
    int sel;
    logic room, hs;
    m_ent_t e, n;
    logic [MO-1:0] exp_en;
    logic [MO-1:0][PB-1:0] exp_prn;
    for (int k = 0; k < MO; k++) bus.prf_op[k] = {$urandom, $urandom};
    @(negedge clk);
    sel = -1;
    room = (mq.size() != D);
    hs = st_v && bus.fu_issue_ready;
    if (!bus.flush && (!st_v || bus.fu_issue_ready))
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && (mq[i].sv & ~mq[i].sr) == '0) sel = i;
    exp_en = '0; exp_prn = '0;
    if (sel >= 0) begin exp_en = mq[sel].sv; exp_prn = mq[sel].sp; end

    chk("occupancy", bus.occupancy, mq.size());
    chk("queue_ready", bus.queue_ready, room);
    chk("prf_read_enable", bus.prf_read_enable, exp_en);
    chk("prf_read_prn", bus.prf_read_prn, exp_prn);
    chk("fu_issue_valid", bus.fu_issue_valid, st_v);
    chk("fu_inst_id", bus.fu_inst_id, st_v ? st_e.id : '0);
    chk("fu_raw_instr", bus.fu_raw_instr, st_v ? st_e.instr : '0);
    chk("fu_instr_pc", bus.fu_instr_pc, st_v ? st_e.pc : '0);
    chk("fu_prn_output_valid", bus.fu_prn_output_valid, st_v ? st_e.dv : '0);
    chk("fu_prn_output", bus.fu_prn_output, st_v ? st_e.dp : '0);
    for (int k = 0; k < MO; k++)
      chk($sformatf("fu_operands[%0d]", k), bus.fu_operands[k],
          (st_v && st_e.sv[k]) ? (st_fresh ? bus.prf_op[k] : st_ops[k]) : 64'd0);

    obs_en = bus.prf_read_enable; obs_vld = bus.fu_issue_valid; obs_id = bus.fu_inst_id;
    obs_occ = bus.occupancy; obs_qr = bus.queue_ready; obs_ops = bus.fu_operands;
    if (|bus.prf_read_enable) strobe_cnt++;
    if (bus.fu_issue_valid && bus.fu_issue_ready && !bus.flush) issued.push_back(bus.fu_inst_id);

    if (bus.flush) begin
      mq.delete();
      st_v = 0;
    end else begin
      if (st_v && st_fresh) st_ops = bus.prf_op;
      if (sel >= 0) begin e = mq[sel]; mq.delete(sel); end
      for (int i = 0; i < mq.size(); i++) begin
        n = mq[i];
        for (int k = 0; k < MO; k++) if (n.sv[k] && tb_hit(n.sp[k])) n.sr[k] = 1'b1;
        mq[i] = n;
      end
      if (bus.inst_valid && room) begin
        n.id = bus.inst_id; n.instr = bus.raw_instr; n.pc = bus.instr_pc;
        n.sv = bus.prn_input_valid; n.sp = bus.prn_input;
        n.dv = bus.prn_output_valid; n.dp = bus.prn_output;
        for (int k = 0; k < MO; k++)
          n.sr[k] = !bus.prn_input_valid[k] || bus.prn_input_ready[k] || tb_hit(bus.prn_input[k]);
        mq.push_back(n);
      end
      if (sel >= 0) begin st_v = 1; st_fresh = 1; st_e = e; end
      else if (hs) st_v = 0;
      else if (st_v) st_fresh = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_queue_ready"}, bus.queue_ready, 0);
    chk({tag, "_occupancy"}, bus.occupancy, 0);
    chk({tag, "_issue_valid"}, bus.fu_issue_valid, 0);
    chk({tag, "_prf_en"}, bus.prf_read_enable, 0);
    chk({tag, "_inst_id"}, bus.fu_inst_id, 0);
  endtask

  initial begin
    logic [MO-1:0][PB-1:0] rp;
    logic [MO-1:0][63:0] held;
    idle();
    bus.prf_op = '0;
    #1 rst = 1;
    #2 reset_checks("por");
    @(posedge clk); #1;
    rst = 0;
    mq.delete(); st_v = 0;

    // Minimum latency: allocate id 5 with ready sources
    idle(); bus.fu_issue_ready = 1; set_alloc(5, 3'b011, 3'b011, {6'd0, 6'd2, 6'd1}); step();
    idle(); bus.fu_issue_ready = 1; step();
    chk("lat_strobe_t1", obs_en, 3'b011);
    idle(); bus.fu_issue_ready = 1; step();
    chk("lat_valid_t2", obs_vld, 1);
    chk("lat_id_t2", obs_id, 5);
    for (int i = 0; i < 2; i++) begin idle(); bus.fu_issue_ready = 1; step(); end

    // Wakeup ordering: 1,2,3 wait on 10,11,12; broadcast 12 then 10
    issued.delete();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.fu_issue_ready = 1;
      rp = '0; rp[0] = PB'(10 + i);
      set_alloc(1 + i, 3'b001, 3'b000, rp); step();
    end
    idle(); bus.fu_issue_ready = 1; bcast(2, 0, 6'd12); step();
    idle(); bus.fu_issue_ready = 1; bcast(0, 1, 6'd10); step();
    for (int i = 0; i < 4; i++) begin idle(); bus.fu_issue_ready = 1; step(); end
    chk("order_count", issued.size(), 2);
    chk("order_first", issued.size() > 0 ? issued[0] : 6'h3f, 3);
    chk("order_second", issued.size() > 1 ? issued[1] : 6'h3f, 1);
    chk("order_left", obs_occ, 1);
    idle(); bus.flush = 1; step();

    // Same-cycle allocation wakeup
    idle(); bus.fu_issue_ready = 1; set_alloc(9, 3'b001, 3'b000, {6'd0, 6'd0, 6'd7});
    bcast(1, 2, 6'd7); step();
    idle(); bus.fu_issue_ready = 1; step();
    chk("samecyc_strobe", obs_en, 3'b001);
    idle(); bus.fu_issue_ready = 1; step();
    chk("samecyc_valid", obs_vld, 1);
    chk("samecyc_id", obs_id, 9);
    idle(); bus.fu_issue_ready = 1; step();

    // Fill, stall, release
    strobe_cnt = 0; issued.delete();
    for (int i = 0; i < 12; i++) begin
      idle(); set_alloc(20 + i, 3'b011, 3'b011, {6'd0, 6'd2, 6'd3}); step();
    end
    chk("full_queue_ready", obs_qr, 0);
    chk("full_occupancy", obs_occ, D);
    held = '0;
    for (int i = 0; i < 5; i++) begin
      idle(); step();
      if (i == 0) held = obs_ops;
      else for (int k = 0; k < MO; k++) chk($sformatf("stall_op[%0d]", k), obs_ops[k], held[k]);
    end
    chk("stall_one_strobe", strobe_cnt, 1);
    for (int i = 0; i < 9; i++) begin idle(); bus.fu_issue_ready = 1; step(); end
    chk("b2b_issues", issued.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("b2b_id[%0d]", i), issued.size() > i ? issued[i] : 6'h3f, 20 + i);
    idle(); bus.fu_issue_ready = 1; step();
    chk("refill_queue_ready", obs_qr, 1);

    // Flush with 4 waiting, stage FRESH and an allocation presented
    for (int i = 0; i < 5; i++) begin
      idle(); bus.fu_issue_ready = 1; set_alloc(40 + i, 3'b001, 3'b000, {6'd0, 6'd0, 6'd30}); step();
    end
    idle(); bus.fu_issue_ready = 1; bcast(3, 1, 6'd30); step();
    idle(); bus.fu_issue_ready = 1; step();
    idle(); bus.fu_issue_ready = 1; bus.flush = 1; set_alloc(50, 3'b001, 3'b001, {6'd0, 6'd0, 6'd1}); step();
    chk("preflush_occupancy", obs_occ, 4);
    chk("preflush_valid", obs_vld, 1);
    issued.delete();
    idle(); bus.fu_issue_ready = 1; step();
    chk("flush_occupancy", obs_occ, 0);
    chk("flush_valid", obs_vld, 0);
    for (int i = 0; i < 3; i++) begin idle(); bus.fu_issue_ready = 1; step(); end
    chk("flush_no_issue", issued.size(), 0);

    // Asynchronous reset with 3 waiting and the stage HELD
    for (int i = 0; i < 4; i++) begin
      idle(); set_alloc(60 + i, 3'b001, 3'b001, {6'd0, 6'd0, 6'd4}); step();
    end
    idle(); step();
    chk("prereset_occupancy", obs_occ, 3);
    #2 rst = 1;
    #1 reset_checks("midrst");
    mq.delete(); st_v = 0;
    @(posedge clk); #1;
    reset_checks("midrst_held");
    rst = 0;
    idle(); step();
    chk("postrst_queue_ready", obs_qr, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(99) < 55) begin
        for (int k = 0; k < MO; k++) rp[k] = PB'($urandom_range(15));
        set_alloc(int'($urandom_range(63)), MO'($urandom), MO'($urandom), rp);
      end
      for (int f = 0; f < FC; f++)
        for (int k = 0; k < MO; k++)
          if ($urandom_range(99) < 12) bcast(f, k, PB'($urandom_range(15)));
      bus.fu_issue_ready = ($urandom_range(99) < 70);
      bus.flush = ($urandom_range(99) < 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fu_issue_queue.md
# fu_issue_queue

Parametrised per-functional-unit issue queue with wakeup, oldest-first select, PRF read and a valid/ready issue handshake to the FU. It sits between the instruction router and one FU and supersedes the fixed single-FU queue wrappers. Generalised over depth, operand count and broadcast-port count, and adds age-ordered select, same-cycle allocation wakeup, a stall-tolerant operand-hold stage and flush.

## Interface

**Parameters**

- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, source/destination slots per instruction
- FU_COUNT, 4, number of wakeup broadcast ports (all FUs, including this one)
- DEPTH, 8, queue entries, ≥2

**Ports**

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous; discard all entries and the read stage
- inst_valid  in  1  allocate request
- queue_ready  out  1  = !rst && count != DEPTH
- inst_id  in  INST_ID_BITS  allocated instruction ID
- raw_instr  in  32  allocated instruction word
- instr_pc  in  64  allocated instruction PC
- prn_input_valid[MAX_OPERANDS]  in  1 each  source slot used
- prn_input_ready[MAX_OPERANDS]  in  1 each  source already written at allocate
- prn_input[MAX_OPERANDS]  in  PRN_BITS each  source PRN
- prn_output_valid[MAX_OPERANDS]  in  1 each  destination slot used
- prn_output[MAX_OPERANDS]  in  PRN_BITS each  destination PRN
- set_prn_ready[FU_COUNT][MAX_OPERANDS]  in  1 each  broadcast valid
- set_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS each  broadcast PRN
- prf_read_enable[MAX_OPERANDS]  out  1 each  PRF read strobe
- prf_read_prn[MAX_OPERANDS]  out  PRN_BITS each  PRF read address
- prf_op[MAX_OPERANDS]  in  64 each  PRF data, valid the cycle after the strobe
- fu_issue_valid  out  1  issue bundle valid
- fu_issue_ready  in  1  FU accepts the bundle
- fu_inst_id, fu_raw_instr, fu_instr_pc  out  INST_ID_BITS/32/64  issued instruction fields
- fu_operands[MAX_OPERANDS]  out  64 each  source values
- fu_prn_output_valid[MAX_OPERANDS], fu_prn_output[MAX_OPERANDS]  out  destination slots
- occupancy  out  $clog2(DEPTH+1)  valid entry count

## Operation

**Entries**
- Each entry holds: valid, id, instr, pc, per-slot src valid/ready/prn, per-slot dst valid/prn.
- Compacting array: index 0 is oldest. Valid entries are always contiguous from 0; count = occupancy.

**Allocate**
- Occurs when inst_valid && queue_ready && !flush.
- Written at index count − (select this cycle ? 1 : 0).
- Src ready bit = !prn_input_valid | prn_input_ready | match against any broadcast this cycle. Same-cycle wakeup is mandatory.

**Wakeup**
- Every cycle, for every valid entry and valid-not-ready slot: set ready if any set_prn_ready[f][k] has set_prn[f][k] == slot prn.

**Select**
- Candidate entry: valid with all used slots ready, using registered ready bits. A same-cycle broadcast does not make an entry selectable that cycle.
- Selection is permitted when the read stage is EMPTY, or when it is occupied and fu_issue_ready=1.
- The lowest-index candidate is removed; entries above it shift down by one.
- On select, drive prf_read_enable[k] = src valid and prf_read_prn[k] = src prn, combinationally. Both are otherwise 0.

**Read stage FSM (EMPTY, FRESH, HELD)**
- Select moves the stage to FRESH and loads the instruction fields.
- In FRESH: fu_operands = prf_op; the operands are latched at the clock edge.
  - Handshake and select → FRESH.
  - Handshake and no select → EMPTY.
  - No handshake → HELD.
- In HELD: fu_operands = latched values.
  - Handshake and select → FRESH.
  - Handshake and no select → EMPTY.
  - Otherwise stay HELD.
- fu_issue_valid = (state != EMPTY).
- Unused operand slots output 0.

**Flush / reset**
- Flush clears all entry valid bits and forces EMPTY. It suppresses the allocation, select and PRF strobes in that cycle.
- Reset does the same asynchronously.
- Reset values: queue_ready 0 while rst is high, then 1. fu_issue_valid 0, occupancy 0, prf_read_enable all 0, all data outputs 0.

## Timing

- Allocate with all sources ready at edge t: selectable in cycle t+1 (PRF strobe in t+1), fu_issue_valid in t+2. Minimum latency is 2 cycles.
- Broadcast in cycle t for a waiting entry: strobe in t+1, issue in t+2.
- With fu_issue_ready held high, one issue per cycle back-to-back.
- Full queue: queue_ready=0 even if a select occurs the same cycle. It rises the cycle after count drops.
- Allocate + select in the same cycle: occupancy unchanged. The new entry lands at the top and age order is preserved.
- Stall: bundle fields and operands stay stable until fu_issue_ready. No PRF re-read occurs.
- Flush in the same cycle as fu_issue_ready: the bundle is still dropped; the FU must ignore the handshake on flush.

## Test plan

- Reset mid-operation with 3 entries and the stage HELD → occupancy 0, fu_issue_valid 0, queue_ready 0 during rst and 1 the cycle after release.
- Allocate id 5, all sources ready → strobe in t+1, fu_issue_valid with fu_inst_id 5 in t+2, fu_operands equal to prf_op of t+2.
- Allocate ids 1, 2, 3 waiting on PRN 10, 11, 12. Broadcast 12 then 10 on different FU ports → issue order 3, 1; id 2 remains.
- Allocate with prn_input=7 not ready while set_prn=7 is broadcast that same cycle → entry issues at t+2.
- Fill to DEPTH → queue_ready 0. Hold fu_issue_ready 0 for 5 cycles → operands stable, one strobe only. Release → one issue per cycle, then queue_ready returns to 1.
- Flush with 4 entries, stage FRESH, and inst_valid=1 → next cycle occupancy 0 and fu_issue_valid 0. The instruction presented with the flush is not allocated.
